// File: rtl/hdlc_rx_frame_queue.sv
// HDLC receive frame queue: buffers up to NUM_FRAMES complete frames from the Rx channel
// while the host drains older ones from the head slot.
module hdlc_rx_frame_queue #(
    parameter int DATA_W     = 8,
    parameter int MAX_BYTES  = 128,
    parameter int NUM_FRAMES = 4,
    parameter int FCS_BYTES  = 2,
    parameter int SIZE_W     = $clog2(MAX_BYTES + 1),
    parameter int CNT_W      = $clog2(NUM_FRAMES + 1)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Rx_WrBuff,
    input  logic [DATA_W-1:0] Rx_Data,
    input  logic              Rx_EoF,
    input  logic              Rx_AbortSignal,
    input  logic              Rx_FrameError,
    input  logic              Rx_FCSen,
    input  logic              Rx_RdBuff,
    input  logic              Rx_Drop,
    output logic              Rx_Ready,
    output logic [SIZE_W-1:0] Rx_FrameSize,
    output logic              Rx_Overflow,
    output logic [DATA_W-1:0] Rx_DataBuffOut,
    output logic [CNT_W-1:0]  Rx_FrameCount,
    output logic [7:0]        Rx_LostCount
);

    localparam int IDX_W = $clog2(MAX_BYTES);
    localparam int PTR_W = $clog2(NUM_FRAMES);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_TRUNC, W_LOST} wstate_t;

    wstate_t           r_wState;
    wstate_t           w_wNext;

    logic [DATA_W-1:0] r_mem  [NUM_FRAMES][MAX_BYTES];
    logic [SIZE_W-1:0] r_size [NUM_FRAMES];
    logic              r_ovf  [NUM_FRAMES];

    logic [PTR_W-1:0]  r_wrSlot;
    logic [PTR_W-1:0]  r_head;
    logic [SIZE_W-1:0] r_bcnt;
    logic [IDX_W-1:0]  r_rdIdx;
    logic [CNT_W-1:0]  r_count;
    logic [7:0]        r_lost;
    logic [DATA_W-1:0] r_dataOut;

    logic              w_kill;
    logic              w_full;
    logic              w_store;
    logic              w_commit;
    logic              w_lostInc;
    logic              w_effOvf;
    logic [SIZE_W-1:0] w_effCnt;
    logic [SIZE_W-1:0] w_strip;
    logic              w_ready;
    logic [SIZE_W-1:0] w_lastIdx;
    logic              w_read;
    logic              w_free;

    assign w_kill  = Rx_AbortSignal | Rx_FrameError;
    assign w_full  = (r_count == CNT_W'(NUM_FRAMES));
    assign w_strip = Rx_FCSen ? SIZE_W'(FCS_BYTES) : '0;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wNext;
        end
    end

    // w_effCnt / w_effOvf describe the frame including a byte written this cycle,
    // so a byte arriving together with Rx_EoF is part of the committed frame.
    always_comb begin
        w_wNext   = r_wState;
        w_store   = 1'b0;
        w_commit  = 1'b0;
        w_lostInc = 1'b0;
        w_effCnt  = r_bcnt;
        w_effOvf  = (r_wState == W_TRUNC);
        if (w_kill) begin
            w_wNext = W_IDLE;
        end else begin
            case (r_wState)
                W_IDLE: begin
                    if (Rx_WrBuff) begin
                        if (w_full) begin
                            w_lostInc = 1'b1;
                            w_wNext   = Rx_EoF ? W_IDLE : W_LOST;
                        end else begin
                            w_store  = 1'b1;
                            w_effCnt = SIZE_W'(1);
                            w_wNext  = W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    if (Rx_WrBuff) begin
                        if (r_bcnt == SIZE_W'(MAX_BYTES)) begin
                            w_effOvf = 1'b1;
                            w_wNext  = W_TRUNC;
                        end else begin
                            w_store  = 1'b1;
                            w_effCnt = r_bcnt + 1'b1;
                        end
                    end
                end
                W_TRUNC: w_wNext = W_TRUNC;
                W_LOST: begin
                    if (Rx_EoF) begin
                        w_wNext = W_IDLE;
                    end
                end
                default: w_wNext = W_IDLE;
            endcase
            if (Rx_EoF && ((r_wState == W_FILL) || (r_wState == W_TRUNC) ||
                           ((r_wState == W_IDLE) && w_store))) begin
                w_commit = (w_effCnt > w_strip);
                w_wNext  = W_IDLE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_bcnt   <= '0;
            r_wrSlot <= '0;
            r_lost   <= '0;
            for (int i = 0; i < NUM_FRAMES; i++) begin
                r_size[i] <= '0;
                r_ovf[i]  <= 1'b0;
            end
        end else begin
            r_bcnt <= (w_wNext == W_IDLE) ? '0 : w_effCnt;
            if (w_commit) begin
                r_size[r_wrSlot] <= w_effCnt - w_strip;
                r_ovf[r_wrSlot]  <= w_effOvf;
                r_wrSlot         <= r_wrSlot + 1'b1;
            end
            if (w_lostInc && (r_lost != 8'hFF)) begin
                r_lost <= r_lost + 8'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_store) begin
            r_mem[r_wrSlot][r_bcnt[IDX_W-1:0]] <= Rx_Data;
        end
    end

    // A truncated frame holds MAX_BYTES data bytes even when its reported size had FCS stripped.
    assign w_ready   = (r_count != '0);
    assign w_lastIdx = r_ovf[r_head] ? SIZE_W'(MAX_BYTES - 1) : (r_size[r_head] - 1'b1);
    assign w_read    = w_ready & Rx_RdBuff & ~Rx_Drop;
    assign w_free    = w_ready & (Rx_Drop | (w_read & (SIZE_W'(r_rdIdx) == w_lastIdx)));

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_head    <= '0;
            r_rdIdx   <= '0;
            r_count   <= '0;
            r_dataOut <= '0;
        end else begin
            if (w_read) begin
                r_dataOut <= r_mem[r_head][r_rdIdx];
            end
            if (w_free) begin
                r_head  <= r_head + 1'b1;
                r_rdIdx <= '0;
            end else if (w_read) begin
                r_rdIdx <= r_rdIdx + 1'b1;
            end
            case ({w_commit, w_free})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign Rx_Ready       = w_ready;
    assign Rx_FrameSize   = w_ready ? r_size[r_head] : '0;
    assign Rx_Overflow    = w_ready & r_ovf[r_head];
    assign Rx_DataBuffOut = r_dataOut;
    assign Rx_FrameCount  = r_count;
    assign Rx_LostCount   = r_lost;

endmodule

// File: tb/tb_hdlc_rx_frame_queue.sv
// Self-checking bench for hdlc_rx_frame_queue: directed scenarios plus randomized traffic,
// compared against a frame-level queue model.
module tb_hdlc_rx_frame_queue;

    localparam int DATA_W     = 8;
    localparam int MAX_BYTES  = 128;
    localparam int NUM_FRAMES = 4;
    localparam int FCS_BYTES  = 2;
    localparam int SIZE_W     = $clog2(MAX_BYTES + 1);
    localparam int CNT_W      = $clog2(NUM_FRAMES + 1);

    logic              Clk = 1'b0;
    logic              Rst;
    logic              Rx_WrBuff;
    logic [DATA_W-1:0] Rx_Data;
    logic              Rx_EoF;
    logic              Rx_AbortSignal;
    logic              Rx_FrameError;
    logic              Rx_FCSen;
    logic              Rx_RdBuff;
    logic              Rx_Drop;
    logic              Rx_Ready;
    logic [SIZE_W-1:0] Rx_FrameSize;
    logic              Rx_Overflow;
    logic [DATA_W-1:0] Rx_DataBuffOut;
    logic [CNT_W-1:0]  Rx_FrameCount;
    logic [7:0]        Rx_LostCount;

    hdlc_rx_frame_queue #(
        .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .NUM_FRAMES(NUM_FRAMES), .FCS_BYTES(FCS_BYTES)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Rx_WrBuff(Rx_WrBuff), .Rx_Data(Rx_Data), .Rx_EoF(Rx_EoF),
        .Rx_AbortSignal(Rx_AbortSignal), .Rx_FrameError(Rx_FrameError), .Rx_FCSen(Rx_FCSen),
        .Rx_RdBuff(Rx_RdBuff), .Rx_Drop(Rx_Drop), .Rx_Ready(Rx_Ready),
        .Rx_FrameSize(Rx_FrameSize), .Rx_Overflow(Rx_Overflow),
        .Rx_DataBuffOut(Rx_DataBuffOut), .Rx_FrameCount(Rx_FrameCount),
        .Rx_LostCount(Rx_LostCount)
    );

    always #5 Clk = ~Clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Frame-level model: queued frame ids in arrival order, with per-frame contents.
    int         mQ[$];
    int         mSize [32];
    bit         mOvf  [32];
    logic [7:0] mData [32][140];
    int         mRdIdx   = 0;
    int         mLost    = 0;
    int         mNextId  = 0;
    logic [7:0] mLastOut = 8'h00;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit wr, input logic [7:0] d, input bit eof, input bit abort,
                                 input bit err, input bit fcs, input bit rd, input bit drop);
        Rx_WrBuff = wr; Rx_Data = d; Rx_EoF = eof; Rx_AbortSignal = abort;
        Rx_FrameError = err; Rx_FCSen = fcs; Rx_RdBuff = rd; Rx_Drop = drop;
        @(posedge Clk);
        #1;
        Rx_WrBuff = 0; Rx_Data = '0; Rx_EoF = 0; Rx_AbortSignal = 0;
        Rx_FrameError = 0; Rx_FCSen = 0; Rx_RdBuff = 0; Rx_Drop = 0;
    endtask

    function automatic int mLimit(input int id);
        return mOvf[id] ? MAX_BYTES : mSize[id];
    endfunction

    function automatic void modelRead();
        if (mQ.size() != 0) begin
            mLastOut = mData[mQ[0]][mRdIdx];
            mRdIdx++;
            if (mRdIdx == mLimit(mQ[0])) begin
                void'(mQ.pop_front());
                mRdIdx = 0;
            end
        end
    endfunction

    task automatic checkState(input string tag);
        bit rdy;
        rdy = (mQ.size() != 0);
        checkOutput({tag, ".ready"}, 32'(Rx_Ready), 32'(rdy));
        checkOutput({tag, ".size"}, 32'(Rx_FrameSize), rdy ? 32'(mSize[mQ[0]]) : 32'd0);
        checkOutput({tag, ".ovf"}, 32'(Rx_Overflow), rdy ? 32'(mOvf[mQ[0]]) : 32'd0);
        checkOutput({tag, ".count"}, 32'(Rx_FrameCount), 32'(mQ.size()));
        checkOutput({tag, ".lost"}, 32'(Rx_LostCount), 32'(mLost));
    endtask

    // endMode: 0 EoF on last byte, 1 abort after, 2 abort together with EoF, 3 error after.
    task automatic sendFrame(input int len, input bit fcs, input int endMode,
                             input bit readOnLast, input int base);
        bit         wasFull;
        int         id;
        logic [7:0] b;
        bit         last;
        int         stored;
        int         strip;
        wasFull = (mQ.size() == NUM_FRAMES);
        id      = mNextId;
        for (int i = 0; i < len; i++) begin
            b    = (base < 0) ? 8'($urandom) : 8'(base + i + 1);
            last = (i == len - 1);
            if (!wasFull && i < MAX_BYTES) mData[id][i] = b;
            if (last && readOnLast) modelRead();
            applyStimulus(1, b, last && (endMode != 1) && (endMode != 3), last && (endMode == 2),
                          0, fcs, last && readOnLast, 0);
            if (last && readOnLast) checkOutput("concRdData", 32'(Rx_DataBuffOut), 32'(mLastOut));
        end
        if (endMode == 1) applyStimulus(0, 8'h00, 0, 1, 0, fcs, 0, 0);
        if (endMode == 3) applyStimulus(0, 8'h00, 0, 0, 1, fcs, 0, 0);
        if (wasFull) begin
            if (mLost < 255) mLost++;
        end else if (endMode == 0) begin
            stored = (len > MAX_BYTES) ? MAX_BYTES : len;
            strip  = fcs ? FCS_BYTES : 0;
            if (stored > strip) begin
                mSize[id] = stored - strip;
                mOvf[id]  = (len > MAX_BYTES);
                mQ.push_back(id);
                mNextId = (mNextId + 1) % 32;
            end
        end
    endtask

    task automatic readBytes(input int n);
        for (int i = 0; i < n; i++) begin
            modelRead();
            applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 0);
            checkOutput("rdData", 32'(Rx_DataBuffOut), 32'(mLastOut));
        end
    endtask

    task automatic drainAll();
        while (mQ.size() != 0) readBytes(1);
    endtask

    task automatic dropHead(input bit alsoRead);
        applyStimulus(0, 8'h00, 0, 0, 0, 0, alsoRead, 1);
        if (mQ.size() != 0) begin
            void'(mQ.pop_front());
            mRdIdx = 0;
        end
        checkOutput("dropData", 32'(Rx_DataBuffOut), 32'(mLastOut));
    endtask

    task automatic resetAndCheck(input string tag);
        Rst = 1'b0;
        #1;
        checkOutput({tag, ".ready"}, 32'(Rx_Ready), 32'd0);
        checkOutput({tag, ".size"}, 32'(Rx_FrameSize), 32'd0);
        checkOutput({tag, ".ovf"}, 32'(Rx_Overflow), 32'd0);
        checkOutput({tag, ".data"}, 32'(Rx_DataBuffOut), 32'd0);
        checkOutput({tag, ".count"}, 32'(Rx_FrameCount), 32'd0);
        checkOutput({tag, ".lost"}, 32'(Rx_LostCount), 32'd0);
        mQ.delete();
        mRdIdx = 0; mLost = 0; mLastOut = 8'h00;
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int op;
        Rst = 1'b0;
        Rx_WrBuff = 0; Rx_Data = '0; Rx_EoF = 0; Rx_AbortSignal = 0;
        Rx_FrameError = 0; Rx_FCSen = 0; Rx_RdBuff = 0; Rx_Drop = 0;
        repeat (2) @(posedge Clk);
        resetAndCheck("reset");

        // 10 bytes with FCS stripping reports 8.
        sendFrame(10, 1, 0, 0, 0);
        checkState("fcs");
        checkOutput("fcs.sizeConst", 32'(Rx_FrameSize), 32'd8);
        readBytes(8);
        checkState("fcsDrained");

        // Queue full: fifth frame lost, then drained in order.
        for (int f = 0; f < 4; f++) sendFrame(5, 0, 0, 0, f * 16);
        sendFrame(5, 0, 0, 0, -1);
        checkState("full");
        checkOutput("full.lostConst", 32'(Rx_LostCount), 32'd1);
        drainAll();
        sendFrame(5, 0, 0, 0, -1);
        checkState("afterFull");
        drainAll();

        // Truncation without and with FCS stripping.
        sendFrame(130, 0, 0, 0, -1);
        checkState("trunc");
        drainAll();
        sendFrame(4, 0, 0, 0, -1);
        checkState("afterTrunc");
        drainAll();
        sendFrame(135, 1, 0, 0, -1);
        checkState("truncFcs");
        readBytes(127);
        checkState("truncFcs127");
        drainAll();
        checkState("truncFcsDone");

        // Abort, abort with EoF, error.
        sendFrame(6, 0, 1, 0, -1);
        sendFrame(3, 0, 0, 0, -1);
        checkState("abort");
        sendFrame(4, 0, 2, 0, -1);
        sendFrame(5, 1, 3, 0, -1);
        checkState("abortEof");
        drainAll();

        // Drop after partial read; last read coinciding with a commit.
        sendFrame(6, 0, 0, 0, -1);
        sendFrame(5, 0, 0, 0, -1);
        readBytes(2);
        dropHead(1);
        checkState("drop");
        readBytes(1);
        drainAll();
        sendFrame(3, 0, 0, 0, -1);
        readBytes(2);
        sendFrame(4, 0, 0, 1, -1);
        checkState("concurrent");
        drainAll();
        readBytes(1);
        checkState("readEmpty");

        // Lost counter saturation.
        for (int f = 0; f < 4; f++) sendFrame(3, 0, 0, 0, -1);
        for (int f = 0; f < 258; f++) sendFrame(2, 0, 0, 0, -1);
        checkState("lostSat");
        drainAll();

        // Reset mid-write and mid-read.
        sendFrame(4, 0, 0, 0, -1);
        applyStimulus(1, 8'h55, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 8'h66, 0, 0, 0, 0, 0, 0);
        resetAndCheck("rstWrite");
        sendFrame(7, 0, 0, 0, -1);
        readBytes(3);
        resetAndCheck("rstRead");
        sendFrame(5, 1, 0, 0, -1);
        checkState("postReset");
        drainAll();

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                sendFrame((($urandom_range(0, 9)) == 0) ? int'($urandom_range(126, 132))
                                                        : int'($urandom_range(2, 20)),
                          1'($urandom), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0,
                          1'($urandom), -1);
            end else if (op < 8) begin
                readBytes(int'($urandom_range(1, 8)));
            end else begin
                dropHead(1'($urandom));
            end
            checkState("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/hdlc_rx_frame_queue.md
Name: hdlc_rx_frame_queue

Overview:
Parametrised successor to the single-frame HDLC receive buffer. It queues up to NUM_FRAMES complete received frames of up to MAX_BYTES bytes each. While the host drains older frames, the receive channel keeps writing new ones. It sits between the Rx channel (byte writes, end-of-frame, abort and error strobes) and the host read path, and presents the head frame's size, overflow flag and data.

Parameters:
DATA_W, 8, byte width of stored data.
MAX_BYTES, 128, per-frame byte capacity, including FCS bytes.
NUM_FRAMES, 4, number of frame slots; power of two, at least 2.
FCS_BYTES, 2, trailing FCS bytes stripped from the reported size when Rx_FCSen=1.
SIZE_W, $clog2(MAX_BYTES+1), width of the size fields (derived).
CNT_W, $clog2(NUM_FRAMES+1), width of the frame count (derived).

Ports:
Clk  in  1  clock; all logic is on the rising edge.
Rst  in  1  asynchronous, active-low reset.
Rx_WrBuff  in  1  write strobe for Rx_Data.
Rx_Data  in  DATA_W  received byte.
Rx_EoF  in  1  end-of-frame strobe; a byte written in the same cycle belongs to the frame.
Rx_AbortSignal  in  1  abort strobe; the frame in progress is discarded.
Rx_FrameError  in  1  error strobe; the frame in progress is discarded.
Rx_FCSen  in  1  FCS stripping enable; sampled at Rx_EoF.
Rx_RdBuff  in  1  host read strobe for the head frame.
Rx_Drop  in  1  drop the head frame immediately.
Rx_Ready  out  1  at least one complete frame is queued.
Rx_FrameSize  out  SIZE_W  reported size of the head frame; 0 when empty.
Rx_Overflow  out  1  head frame was truncated; 0 when empty.
Rx_DataBuffOut  out  DATA_W  last byte read.
Rx_FrameCount  out  CNT_W  number of committed frames queued.
Rx_LostCount  out  8  frames lost because the queue was full; saturates at 255.

Behaviour:
- Reset: all outputs 0, queue empty, writer in W_IDLE, all pointers 0. Reset mid-frame discards everything.
- Storage: NUM_FRAMES x MAX_BYTES array. Write slot pointer and head slot pointer wrap modulo NUM_FRAMES.
- Writer FSM:
  - W_IDLE -> W_FILL on Rx_WrBuff if Rx_FrameCount < NUM_FRAMES. The byte is stored at index 0 and bytecount becomes 1.
  - W_IDLE -> W_LOST on Rx_WrBuff if the queue is full. Rx_LostCount increments once for that frame.
  - W_FILL: each Rx_WrBuff stores at index bytecount, then bytecount increments.
  - W_FILL -> W_TRUNC on Rx_WrBuff when bytecount == MAX_BYTES. The byte is not stored and the slot overflow flag is set.
  - W_TRUNC: further writes are ignored until end of frame.
  - W_FILL/W_TRUNC on Rx_EoF:
    - Let strip = Rx_FCSen ? FCS_BYTES : 0.
    - If bytecount > strip: commit with size = bytecount - strip, advance the write slot, increment the frame count.
    - Otherwise: discard.
    - Either way -> W_IDLE.
  - Abort or error in any state (Rx_AbortSignal or Rx_FrameError) -> W_IDLE, with no commit. This takes priority over Rx_EoF in the same cycle.
  - W_LOST -> W_IDLE on Rx_EoF, abort or error.
  - Rx_EoF while in W_IDLE is ignored.
- Reader:
  - Rx_RdBuff with Rx_Ready=1 latches store[head][rdidx] into Rx_DataBuffOut at the next edge, and rdidx increments.
  - Rx_RdBuff with Rx_Ready=0 is ignored; Rx_DataBuffOut holds its value.
  - When the read of byte index size-1 completes (or of byte MAX_BYTES-1 for a truncated frame with stripped bytes), at that same edge the head advances, rdidx returns to 0 and the frame count decrements.
  - Rx_Drop with Rx_Ready=1 frees the head at the next edge and rdidx returns to 0. Rx_Drop has priority over a simultaneous Rx_RdBuff.
- Simultaneous commit and free in one cycle: the frame count is unchanged, and both pointers advance.
- Outputs are registered from state:
  - Rx_Ready = (Rx_FrameCount != 0).
  - Rx_FrameSize and Rx_Overflow come from the head slot metadata.
  - A freshly committed frame is visible 1 cycle after Rx_EoF.
- Any writer behaviour never alters a committed slot.

Test Plan:
- 10 bytes 0x01..0x0A, Rx_EoF on the 10th, Rx_FCSen=1 -> next cycle Rx_Ready=1, Rx_FrameSize=8. Eight reads return 0x01..0x08. After the 8th read Rx_Ready=0 and Rx_FrameCount=0.
- Four 5-byte frames (FCSen=0), then a fifth frame while none has been read -> Rx_FrameCount=4, Rx_LostCount=1. Draining returns the four frames in order; a subsequent sixth frame is accepted.
- 130 bytes, EoF, FCSen=0 with MAX_BYTES=128 -> Rx_FrameSize=128, Rx_Overflow=1, bytes 129 and 130 not stored. The next frame has Rx_Overflow=0.
- 6 bytes then Rx_AbortSignal, followed by a 3-byte frame -> only the 3-byte frame is queued. Abort and Rx_EoF asserted together also yield no commit.
- Two frames queued; Rx_Drop after 2 reads of frame 1 -> the head becomes frame 2 and the first read returns its byte 0. The last read of a frame coinciding with a new commit leaves Rx_FrameCount unchanged.
- Rst low mid-read and mid-write -> all outputs 0 immediately. Post-reset frames start at slot 0.
